// File: rtl/riscv_cmd_pkg.sv
// rtl/riscv_cmd_pkg.sv - RV32I subset encodings and executor state type
package riscv_cmd_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0]  F3_ADDSUB  = 3'b000;
    localparam logic [6:0]  F7_ADD     = 7'b0000000;
    localparam logic [6:0]  F7_SUB     = 7'b0100000;

    localparam logic [31:0] INSN_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } state_t;

endpackage

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 register file, x0 hardwired to zero, plus debug read port
module riscv_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is masked on read as well, so its storage never matters
    assign rdata_a  = (raddr_a  == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == 5'd0) ? 32'd0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: rtl/riscv_cmd_executor.sv
// rtl/riscv_cmd_executor.sv - single-cycle executor for ADD/SUB/ADDI/LUI with EBREAK halt
module riscv_cmd_executor
    import riscv_cmd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_data,
    output logic             cmd_ready,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] retired_count,
    output logic             halted,
    output logic             illegal,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
);

    state_t state;
    state_t state_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    logic        is_add;
    logic        is_sub;
    logic        is_addi;
    logic        is_lui;
    logic        is_ebreak;
    logic        is_alu;
    logic        accept;
    logic        retire;
    logic [31:0] result;

    assign opcode = cmd_data[6:0];
    assign rd     = cmd_data[11:7];
    assign funct3 = cmd_data[14:12];
    assign rs1    = cmd_data[19:15];
    assign rs2    = cmd_data[24:20];
    assign funct7 = cmd_data[31:25];
    assign imm_i  = {{20{cmd_data[31]}}, cmd_data[31:20]};
    assign imm_u  = {cmd_data[31:12], 12'b0};

    assign is_add    = (opcode == OPC_OP) && (funct3 == F3_ADDSUB) && (funct7 == F7_ADD);
    assign is_sub    = (opcode == OPC_OP) && (funct3 == F3_ADDSUB) && (funct7 == F7_SUB);
    assign is_addi   = (opcode == OPC_OPIMM) && (funct3 == F3_ADDSUB);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_ebreak = (cmd_data == INSN_EBREAK);
    assign is_alu    = is_add | is_sub | is_addi | is_lui;

    assign accept = cmd_valid & cmd_ready;
    assign retire = accept & is_alu;

    always_comb begin
        result = 32'd0;
        if (is_add) begin
            result = rs1_data + rs2_data;
        end else if (is_sub) begin
            result = rs1_data - rs2_data;
        end else if (is_addi) begin
            result = rs1_data + imm_i;
        end else if (is_lui) begin
            result = imm_u;
        end
    end

    riscv_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (retire),
        .waddr    (rd),
        .wdata    (result),
        .raddr_a  (rs1),
        .rdata_a  (rs1_data),
        .raddr_b  (rs2),
        .rdata_b  (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // HALTED and ERROR are sticky; only reset returns to RUN
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            RUN: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    if (is_ebreak) begin
                        state_next = HALTED;
                    end else if (!is_alu) begin
                        state_next = ERROR;
                    end
                end
            end
            HALTED: halted  = 1'b1;
            ERROR:  illegal = 1'b1;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                wb_rd   <= rd;
                wb_data <= result;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire && !(&retired_count)) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_cmd_executor.sv
// tb/tb_riscv_cmd_executor.sv - directed self-checking bench for riscv_cmd_executor
module tb_riscv_cmd_executor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] retired_count;
    logic        halted;
    logic        illegal;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad = 0;

    riscv_cmd_executor #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .retired_count (retired_count),
        .halted        (halted),
        .illegal       (illegal),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] word);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = word;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #0.5;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        total++; if (retired_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
        total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", halted, illegal); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        rd_reg(5'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_x1 got=%h exp=0", v); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        issue(32'h00500093);
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'd5) begin bad++; $display("FAIL basic_wb1 got=%0b/%0d/%h exp=1/1/5", wb_valid, wb_rd, wb_data); end
        issue(32'h00700113);
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'd7) begin bad++; $display("FAIL basic_wb2 got=%0b/%0d/%h exp=1/2/7", wb_valid, wb_rd, wb_data); end
        issue(32'h002081B3);
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin bad++; $display("FAIL basic_wb3 got=%0b/%0d/%h exp=1/3/c", wb_valid, wb_rd, wb_data); end
        idle(1);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_end got=%0b exp=0", wb_valid); end
        total++; if (retired_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", retired_count); end
        rd_reg(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL basic_x1 got=%h exp=5", v); end
        rd_reg(5'd2, v);
        total++; if (v !== 32'd7) begin bad++; $display("FAIL basic_x2 got=%h exp=7", v); end
        rd_reg(5'd3, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL basic_x3 got=%h exp=c", v); end
    endtask

    task automatic test_sub_sext();
        logic [31:0] v;
        issue(32'h40208233);
        issue(32'hFFF00313);
        idle(1);
        rd_reg(5'd4, v);
        total++; if (v !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_x4 got=%h exp=fffffffe", v); end
        rd_reg(5'd6, v);
        total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("FAIL sext_x6 got=%h exp=ffffffff", v); end
        total++; if (retired_count !== 16'd5) begin bad++; $display("FAIL sub_count got=%0d exp=5", retired_count); end
    endtask

    task automatic test_lui_x0();
        logic [31:0] v;
        issue(32'h123452B7);
        total++; if (wb_rd !== 5'd5 || wb_data !== 32'h12345000) begin bad++; $display("FAIL lui_wb got=%0d/%h exp=5/12345000", wb_rd, wb_data); end
        issue(32'h00100013);
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_data !== 32'd1) begin bad++; $display("FAIL x0_wb got=%0b/%0d/%h exp=1/0/1", wb_valid, wb_rd, wb_data); end
        idle(1);
        rd_reg(5'd5, v);
        total++; if (v !== 32'h12345000) begin bad++; $display("FAIL lui_x5 got=%h exp=12345000", v); end
        rd_reg(5'd0, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL x0_read got=%h exp=0", v); end
        total++; if (retired_count !== 16'd7) begin bad++; $display("FAIL lui_count got=%0d exp=7", retired_count); end
    endtask

    task automatic test_ebreak();
        logic [31:0] v;
        issue(32'h00100073);
        total++; if (halted !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL ebreak_state got=h%0b/r%0b exp=h1/r0", halted, cmd_ready); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ebreak_wb got=%0b exp=0", wb_valid); end
        issue(32'h00500093);
        issue(32'h00900093);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ebreak_held_wb got=%0b exp=0", wb_valid); end
        idle(1);
        rd_reg(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL ebreak_x1 got=%h exp=5", v); end
        total++; if (retired_count !== 16'd7) begin bad++; $display("FAIL ebreak_count got=%0d exp=7", retired_count); end
        total++; if (halted !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL ebreak_sticky got=%0b%0b exp=10", halted, illegal); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(32'h00500093);
        issue(32'h00700113);
        dbg_addr = 5'd1;
        #1;
        reset = 1'b1;
        #1;
        total++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL async_wb got=%0b/%0d/%h exp=0/0/0", wb_valid, wb_rd, wb_data); end
        total++; if (retired_count !== 16'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", retired_count); end
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL async_x1 got=%h exp=0", dbg_data); end
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL async_ready got=%0b exp=1", cmd_ready); end
        rd_reg(5'd2, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL async_x2 got=%h exp=0", v); end
    endtask

    task automatic test_stalls();
        logic [31:0] v;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            issue(32'h00108093);
            if (wb_valid === 1'b1) pulses++;
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                @(posedge clk);
                #1;
                if (wb_valid === 1'b1) pulses++;
            end
        end
        total++; if (pulses !== 3) begin bad++; $display("FAIL stall_pulses got=%0d exp=3", pulses); end
        rd_reg(5'd1, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL stall_x1 got=%h exp=3", v); end
        total++; if (retired_count !== 16'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", retired_count); end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        issue(32'h00000000);
        total++; if (illegal !== 1'b1 || cmd_ready !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL illegal_state got=i%0b/r%0b/h%0b exp=i1/r0/h0", illegal, cmd_ready, halted); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL illegal_wb got=%0b exp=0", wb_valid); end
        issue(32'h00108093);
        idle(1);
        rd_reg(5'd1, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL illegal_x1 got=%h exp=3", v); end
        total++; if (retired_count !== 16'd3) begin bad++; $display("FAIL illegal_count got=%0d exp=3", retired_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_sext();
        test_lui_x0();
        test_ebreak();
        test_async_reset();
        test_stalls();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
